// File: rtl/anim_pkg.sv
// Shared types and per-animation frame limits for the 7-segment animation engine.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package anim_pkg;

    localparam int NUM_ANIM = 12;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PAUSED,
        ST_SWITCH
    } state_t;

    // Frames per animation; animations 2..6 share one length.
    localparam logic [4:0] LIMIT_A0      = 5'd10;
    localparam logic [4:0] LIMIT_A1      = 5'd12;
    localparam logic [4:0] LIMIT_A2_6    = 5'd6;
    localparam logic [4:0] LIMIT_A7      = 5'd2;
    localparam logic [4:0] LIMIT_A8      = 5'd4;
    localparam logic [4:0] LIMIT_A9      = 5'd4;
    localparam logic [4:0] LIMIT_A10     = 5'd2;
    localparam logic [4:0] LIMIT_A11     = 5'd2;
    localparam logic [4:0] LIMIT_INVALID = 5'd31;

endpackage

// File: rtl/frame_limit.sv
// Frame-count lookup per animation, shared with the segment-pattern decoder.
// Latency: combinational.
// Backpressure: none.
module frame_limit
    import anim_pkg::*;
(
    input  logic [3:0] animation,
    output logic [4:0] limit
);

    always_comb begin
        limit = LIMIT_INVALID;
        case (animation)
            4'd0:                         limit = LIMIT_A0;
            4'd1:                         limit = LIMIT_A1;
            4'd2, 4'd3, 4'd4, 4'd5, 4'd6: limit = LIMIT_A2_6;
            4'd7:                         limit = LIMIT_A7;
            4'd8:                         limit = LIMIT_A8;
            4'd9:                         limit = LIMIT_A9;
            4'd10:                        limit = LIMIT_A10;
            4'd11:                        limit = LIMIT_A11;
            default:                      limit = LIMIT_INVALID;
        endcase
    end

endmodule

// File: rtl/anim_sequencer.sv
// Frame sequencer: holds active animation/frame, advances on a prescaled tick or step.
// Latency: anim_sel -> animation 1 edge; step rise -> frame 2 edges; outputs registered.
// Backpressure: none; the pattern decoder samples animation/frame every cycle.
module anim_sequencer #(
    parameter int DIV_BASE = 10_000_000,
    parameter int NUM_ANIM = anim_pkg::NUM_ANIM
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anim_sel,
    input  logic [1:0] speed,
    input  logic       pause,
    input  logic       step,
    input  logic       auto_mode,
    output logic [3:0] animation,
    output logic [4:0] frame,
    output logic       frame_strobe,
    output logic       wrap
);

    import anim_pkg::*;

    localparam int          PW         = $clog2(DIV_BASE);
    localparam logic [31:0] DIV_W      = 32'(DIV_BASE);
    localparam logic [4:0]  NUM_ANIM_W = 5'(NUM_ANIM);
    localparam logic [3:0]  LAST_ANIM  = 4'(NUM_ANIM - 1);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic [31:0]   term;
    logic          tick;
    logic          step_r;
    logic          step_q;
    logic          step_rise;
    logic [4:0]    limit;
    logic [4:0]    last_frame;
    logic          switch_req;
    logic          adv;
    logic [3:0]    anim_nxt;
    logic [4:0]    frame_nxt;
    logic          strobe_nxt;
    logic          wrap_nxt;

    frame_limit u_frame_limit (
        .animation (animation),
        .limit     (limit)
    );

    assign last_frame = limit - 5'd1;

    // Terminal count follows speed immediately; >= catches a shrink below the current count.
    assign term = (DIV_W >> speed) - 32'd1;
    assign tick = (32'(pcnt) >= term);

    // step is registered once before edge detection, so frame moves two edges after the pin rises.
    assign step_rise = step_r & ~step_q;

    // Auto-cycle owns animation selection; out-of-range requests are dropped.
    assign switch_req = ~auto_mode
                      && (anim_sel != animation)
                      && ({1'b0, anim_sel} < NUM_ANIM_W);

    always_comb begin
        pcnt_nxt = pcnt + PW'(1);
        if (switch_req || tick) begin
            pcnt_nxt = '0;
        end
    end

    always_comb begin
        state_nxt  = pause ? ST_PAUSED : ST_RUN;
        adv        = 1'b0;
        anim_nxt   = animation;
        frame_nxt  = frame;
        strobe_nxt = 1'b0;
        wrap_nxt   = 1'b0;

        case (state)
            ST_RUN:    adv = tick;
            ST_PAUSED: adv = step_rise;
            default:   adv = 1'b0;
        endcase

        if (switch_req) begin
            state_nxt  = ST_SWITCH;
            anim_nxt   = anim_sel;
            frame_nxt  = 5'd0;
            strobe_nxt = 1'b1;
        end else if (adv) begin
            strobe_nxt = 1'b1;
            if (frame == last_frame) begin
                frame_nxt = 5'd0;
                wrap_nxt  = 1'b1;
                if (auto_mode) begin
                    anim_nxt = (animation == LAST_ANIM) ? 4'd0 : animation + 4'd1;
                end
            end else begin
                frame_nxt = frame + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt         <= '0;
            step_r       <= 1'b0;
            step_q       <= 1'b0;
            animation    <= 4'd0;
            frame        <= 5'd0;
            frame_strobe <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            pcnt         <= pcnt_nxt;
            step_r       <= step;
            step_q       <= step_r;
            animation    <= anim_nxt;
            frame        <= frame_nxt;
            frame_strobe <= strobe_nxt;
            wrap         <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_anim_sequencer.sv
// Scoreboard bench for anim_sequencer at DIV_BASE=8: every strobe is matched against
// an expected (edge, animation, frame, wrap) event queued by the stimulus.
module tb_anim_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] anim_sel = 4'd0;
    logic [1:0] speed = 2'd0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic       auto_mode = 1'b0;
    logic [3:0] animation;
    logic [4:0] frame;
    logic       frame_strobe;
    logic       wrap;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int r0 = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [3:0] anim;
        logic [4:0] frame;
        logic       wrap;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;

    anim_sequencer #(
        .DIV_BASE (8),
        .NUM_ANIM (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .anim_sel     (anim_sel),
        .speed        (speed),
        .pause        (pause),
        .step         (step),
        .auto_mode    (auto_mode),
        .animation    (animation),
        .frame        (frame),
        .frame_strobe (frame_strobe),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int a, input int f, input bit w);
        ev_t e;
        e.cyc   = c;
        e.anim  = 4'(a);
        e.frame = 5'(f);
        e.wrap  = w;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Leaves the bench at the negedge after the last reset edge; r0 is that edge number.
    task automatic do_reset(input logic [3:0] sel, input logic [1:0] spd);
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        anim_sel = sel;
        speed = spd;
        pause = 1'b0;
        step = 1'b0;
        auto_mode = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        chk("rst_anim", 32'(animation), 0);
        chk("rst_frame", 32'(frame), 0);
        chk("rst_strobe", 32'(frame_strobe), 0);
        chk("rst_wrap", 32'(wrap), 0);
        r0 = cyc;
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en && (frame_strobe || wrap)) begin
            if (sb.size() == 0) begin
                chk("unexp_strobe", 32'(frame_strobe | wrap), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("ev_edge", 32'(cyc), 32'(mon_e.cyc));
                chk("ev_anim", 32'(animation), 32'(mon_e.anim));
                chk("ev_frame", 32'(frame), 32'(mon_e.frame));
                chk("ev_wrap", 32'(wrap), 32'(mon_e.wrap));
                chk("ev_strobe", 32'(frame_strobe), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: animation 0 at period 8, wrap 80 edges after reset
        do_reset(4'd0, 2'd0);
        for (int k = 1; k <= 10; k++) push_ev(r0 + 8 * k, 0, k % 10, k == 10);
        wait_until(r0 + 84);
        chk("s1_drain", 32'(sb.size()), 0);

        // 2: animation 7 at period 1 toggles every edge after the switch cycle
        do_reset(4'd7, 2'd3);
        push_ev(r0 + 1, 7, 0, 1'b0);
        for (int k = 2; k <= 9; k++) push_ev(r0 + 1 + k, 7, (k % 2 == 0) ? 1 : 0, k % 2 == 1);
        wait_until(r0 + 9);
        pause = 1'b1;
        wait_until(r0 + 13);
        chk("s2_drain", 32'(sb.size()), 0);

        // 3: pause at frame 3 of animation 1, two single steps, ticks ignored
        do_reset(4'd1, 2'd0);
        push_ev(r0 + 1, 1, 0, 1'b0);
        for (int k = 1; k <= 3; k++) push_ev(r0 + 1 + 8 * k, 1, k, 1'b0);
        push_ev(r0 + 32, 1, 4, 1'b0);
        push_ev(r0 + 36, 1, 5, 1'b0);
        wait_until(r0 + 26);
        pause = 1'b1;
        for (int p = 0; p < 2; p++) begin
            wait_until(r0 + 30 + 4 * p);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
        end
        wait_until(r0 + 52);
        chk("s3_drain", 32'(sb.size()), 0);
        chk("s3_hold", 32'(frame), 5);

        // 4: auto-cycle wraps animation 11 into 0, which runs all 10 frames into 1
        do_reset(4'd11, 2'd3);
        push_ev(r0 + 1, 11, 0, 1'b0);
        push_ev(r0 + 3, 11, 1, 1'b0);
        push_ev(r0 + 4, 0, 0, 1'b1);
        for (int k = 1; k <= 9; k++) push_ev(r0 + 4 + k, 0, k, 1'b0);
        push_ev(r0 + 14, 1, 0, 1'b1);
        push_ev(r0 + 15, 1, 1, 1'b0);
        wait_until(r0 + 1);
        auto_mode = 1'b1;
        wait_until(r0 + 14);
        pause = 1'b1;
        wait_until(r0 + 18);
        chk("s4_drain", 32'(sb.size()), 0);

        // 5: switch to 9 on the edge a tick is due; the switch wins and restarts the period
        do_reset(4'd2, 2'd0);
        push_ev(r0 + 1, 2, 0, 1'b0);
        push_ev(r0 + 9, 2, 1, 1'b0);
        push_ev(r0 + 17, 2, 2, 1'b0);
        push_ev(r0 + 25, 9, 0, 1'b0);
        for (int k = 1; k <= 4; k++) push_ev(r0 + 25 + 8 * k, 9, k % 4, k == 4);
        wait_until(r0 + 24);
        anim_sel = 4'd9;
        wait_until(r0 + 60);
        chk("s5_drain", 32'(sb.size()), 0);

        // 6: invalid anim_sel ignored, then reset mid-frame
        do_reset(4'd4, 2'd0);
        push_ev(r0 + 1, 4, 0, 1'b0);
        for (int k = 1; k <= 6; k++) push_ev(r0 + 1 + 8 * k, 4, k % 6, k == 6);
        wait_until(r0 + 10);
        anim_sel = 4'd13;
        wait_until(r0 + 52);
        chk("s6_drain", 32'(sb.size()), 0);
        chk("s6_anim", 32'(animation), 4);
        rst = 1'b1;
        @(negedge clk);
        chk("s6_rst_anim", 32'(animation), 0);
        chk("s6_rst_frame", 32'(frame), 0);
        chk("s6_rst_strobe", 32'(frame_strobe), 0);
        chk("s6_rst_wrap", 32'(wrap), 0);
        r0 = cyc;
        rst = 1'b0;
        push_ev(r0 + 8, 0, 1, 1'b0);
        wait_until(r0 + 10);
        chk("s6_post_drain", 32'(sb.size()), 0);

        // 7: speed raised while pcnt is past the new terminal count ticks at once
        do_reset(4'd0, 2'd0);
        push_ev(r0 + 6, 0, 1, 1'b0);
        push_ev(r0 + 8, 0, 2, 1'b0);
        push_ev(r0 + 10, 0, 3, 1'b0);
        wait_until(r0 + 5);
        speed = 2'd2;
        wait_until(r0 + 10);
        pause = 1'b1;
        wait_until(r0 + 15);
        chk("s7_drain", 32'(sb.size()), 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
